// File: rtl/vga_stream_tx.sv
// VGA raster generator that streams pixels from a fixed-latency memory.
// Latency RD_LAT+1 clocks from mem_rd_en to VGA_*; no backpressure, only enable is sampled at frame end.
module vga_stream_tx #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int RD_LAT   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic        mem_rd_en,
   output logic [18:0] mem_addr,
   input  logic [23:0] mem_rdata,
   output logic [7:0]  VGA_R,
   output logic [7:0]  VGA_G,
   output logic [7:0]  VGA_B,
   output logic        VGA_BLANK_N,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [HW-1:0]   r_h_cnt;
   logic [VW-1:0]   r_v_cnt;
   logic            w_run;
   logic            w_line_end;
   logic            w_frame_end;
   logic            w_vis;
   logic            w_hs_n;
   logic            w_vs_n;
   logic            w_fs;
   logic [RD_LAT:0] r_vis_p;
   logic [RD_LAT:0] r_hs_p;
   logic [RD_LAT:0] r_vs_p;
   logic [RD_LAT:0] r_fs_p;

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // enable only matters in IDLE and on the very last clock of a frame
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (enable) w_state_nxt = S_RUN;
         S_RUN:   if (w_frame_end && !enable) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_run       = (r_state == S_RUN);
      w_line_end  = w_run && (r_h_cnt == H_LAST);
      w_frame_end = w_line_end && (r_v_cnt == V_LAST);
      w_vis       = w_run && (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
      w_hs_n      = !(w_run && (r_h_cnt >= H_SS) && (r_h_cnt < H_SE));
      w_vs_n      = !(w_run && (r_v_cnt >= V_SS) && (r_v_cnt < V_SE));
      w_fs        = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset || !w_run) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_line_end) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + VW'(1);
      end else begin
         r_h_cnt <= r_h_cnt + HW'(1);
      end
   end

   // Reads are strictly sequential inside a frame, so the address is a running count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
      end else begin
         mem_rd_en <= w_vis;
         if (w_vis) mem_addr <= w_fs ? '0 : mem_addr + 19'd1;
      end
   end

   // Index 0 lines up with mem_rd_en, index RD_LAT with the returning mem_rdata.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_vis_p <= '0;
         r_hs_p  <= '1;
         r_vs_p  <= '1;
         r_fs_p  <= '0;
      end else begin
         r_vis_p <= {r_vis_p[RD_LAT-1:0], w_vis};
         r_hs_p  <= {r_hs_p[RD_LAT-1:0], w_hs_n};
         r_vs_p  <= {r_vs_p[RD_LAT-1:0], w_vs_n};
         r_fs_p  <= {r_fs_p[RD_LAT-1:0], w_fs};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
         VGA_BLANK_N <= 1'b0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         VGA_R       <= r_vis_p[RD_LAT] ? mem_rdata[23:16] : '0;
         VGA_G       <= r_vis_p[RD_LAT] ? mem_rdata[15:8]  : '0;
         VGA_B       <= r_vis_p[RD_LAT] ? mem_rdata[7:0]   : '0;
         VGA_BLANK_N <= r_vis_p[RD_LAT];
         VGA_HS      <= r_hs_p[RD_LAT];
         VGA_VS      <= r_vs_p[RD_LAT];
         frame_start <= r_fs_p[RD_LAT];
      end
   end
endmodule

// File: tb/tb_vga_stream_tx.sv
// Bench for vga_stream_tx on a shrunken raster: raster-position reference model,
// latency-accurate memory model and run-length statistics on the sync/blank outputs.
module tb_vga_stream_tx;
   localparam int HA = 8, HFP = 2, HSY = 3, HBP = 2;
   localparam int VA = 6, VFP = 1, VSY = 2, VBP = 1;
   localparam int RD_LAT = 2;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FT = HT * VT;
   localparam int L  = RD_LAT + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        mem_rd_en;
   logic [18:0] mem_addr;
   logic [23:0] mem_rdata;
   logic [7:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_BLANK_N, VGA_HS, VGA_VS, frame_start;

   vga_stream_tx #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .VGA_BLANK_N(VGA_BLANK_N), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Memory returns address XOR a per-run salt after exactly RD_LAT clocks, noise otherwise.
   logic [23:0]     salt;
   logic [23:0]     noise;
   logic [RD_LAT-1:0] ml_v;
   logic [18:0]     ml_a [RD_LAT];

   initial begin
      salt  = 24'($urandom);
      noise = 24'($urandom);
      ml_v  = '0;
      for (int i = 0; i < RD_LAT; i++) ml_a[i] = '0;
   end

   always @(posedge clk) begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
         ml_v[i] <= ml_v[i-1];
         ml_a[i] <= ml_a[i-1];
      end
      ml_v[0] <= mem_rd_en;
      ml_a[0] <= mem_addr;
      noise   <= 24'($urandom);
   end

   assign mem_rdata = ml_v[RD_LAT-1] ? ({5'd0, ml_a[RD_LAT-1]} ^ salt) : noise;

   typedef struct packed {
      logic        vis;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [18:0] addr;
   } desc_t;

   localparam desc_t IDLE_D = '{vis: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, addr: 19'd0};

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   bit    m_run = 0;
   int    m_t = 0;
   desc_t d [0:L];
   logic [18:0] e_addr = '0;

   bit    stats_on = 0;
   int    rel_cyc = 0;
   int    first_rd = -1, first_bl = -1, first_fs = -1;
   int    rd_cnt = 0, fs_cnt = 0, last_fs = -1;
   int    run_hs = 0, run_vs = 0, run_bl = 0;
   logic [18:0] last_rd_addr = '0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // One clock: advance the raster model by the rules, then compare every output.
   task automatic step();
      desc_t nd;
      int h, v;
      logic [23:0] e_rgb;
      @(posedge clk);
      cyc++;
      if (!reset) begin
         m_run  = 0;
         m_t    = 0;
         e_addr = '0;
         for (int i = 0; i <= L; i++) d[i] = IDLE_D;
      end else begin
         h = m_t % HT;
         v = m_t / HT;
         nd.vis  = m_run && h < HA && v < VA;
         nd.hs   = !(m_run && h >= HA + HFP && h < HA + HFP + HSY);
         nd.vs   = !(m_run && v >= VA + VFP && v < VA + VFP + VSY);
         nd.fs   = m_run && m_t == 0;
         nd.addr = 19'(v * HA + h);
         for (int i = L; i > 0; i--) d[i] = d[i-1];
         d[0] = nd;
         if (nd.vis) e_addr = nd.addr;
         if (!m_run) begin
            if (enable) m_run = 1;
            m_t = 0;
         end else if (m_t == FT - 1) begin
            m_run = enable;
            m_t   = 0;
         end else begin
            m_t++;
         end
      end
      #1;
      e_rgb = d[L].vis ? ({5'd0, d[L].addr} ^ salt) : 24'd0;
      check_eq("rd_en",   mem_rd_en, d[0].vis);
      check_eq("addr",    mem_addr, e_addr);
      check_eq("rgb",     {VGA_R, VGA_G, VGA_B}, e_rgb);
      check_eq("blank_n", VGA_BLANK_N, d[L].vis);
      check_eq("hs",      VGA_HS, d[L].hs);
      check_eq("vs",      VGA_VS, d[L].vs);
      check_eq("fs",      frame_start, d[L].fs);
      if (stats_on) begin
         if (mem_rd_en) begin
            rd_cnt++;
            last_rd_addr = mem_addr;
            if (first_rd < 0) first_rd = cyc - rel_cyc;
         end
         if (VGA_BLANK_N && first_bl < 0) first_bl = cyc - rel_cyc;
         if (frame_start) begin
            if (first_fs < 0) first_fs = cyc - rel_cyc;
            if (last_fs >= 0) check_eq("fs_period", cyc - last_fs, FT);
            last_fs = cyc;
            fs_cnt++;
         end
         if (!VGA_HS) run_hs++;
         else if (run_hs > 0) begin check_eq("hs_width", run_hs, HSY); run_hs = 0; end
         if (!VGA_VS) run_vs++;
         else if (run_vs > 0) begin check_eq("vs_width", run_vs, VSY * HT); run_vs = 0; end
         if (VGA_BLANK_N) run_bl++;
         else if (run_bl > 0) begin check_eq("line_px", run_bl, HA); run_bl = 0; end
      end
   endtask

   initial begin
      int budget;
      for (int i = 0; i <= L; i++) d[i] = IDLE_D;

      // Reset for 3 clocks, then three back-to-back frames with enable dropped mid third frame.
      reset  = 1'b0;
      enable = 1'b1;
      repeat (3) step();
      reset    = 1'b1;
      rel_cyc  = cyc;
      stats_on = 1;
      repeat (2 * FT + 10) step();
      enable = 1'b0;
      repeat (FT + 20) step();
      stats_on = 0;
      check_eq("first_rd",   first_rd, 2);
      check_eq("first_bl",   first_bl, RD_LAT + 3);
      check_eq("first_fs",   first_fs, RD_LAT + 3);
      check_eq("reads",      rd_cnt, 3 * HA * VA);
      check_eq("frames",     fs_cnt, 3);
      check_eq("last_addr",  last_rd_addr, HA * VA - 1);
      check_eq("idle_rd",    mem_rd_en, 1'b0);
      check_eq("idle_hs_vs", {VGA_HS, VGA_VS, VGA_BLANK_N}, 3'b110);

      // Random enable: only the value on the last clock of a frame may change anything.
      for (int n = 0; n < 900; n++) begin
         enable = ($urandom_range(0, 3) != 0);
         step();
      end
      enable = 1'b0;
      repeat (FT + 10) step();

      // Reset mid-line inside the visible area, then restart.
      enable = 1'b1;
      budget = 2 * FT;
      while (!(m_run && m_t == 2 * HT + 3) && budget > 0) begin
         step();
         budget--;
      end
      check_eq("reach_mid", m_t, 2 * HT + 3);
      reset = 1'b0;
      step();
      check_eq("rst_rd",    mem_rd_en, 1'b0);
      check_eq("rst_addr",  mem_addr, 19'd0);
      check_eq("rst_blank", VGA_BLANK_N, 1'b0);
      check_eq("rst_sync",  {VGA_HS, VGA_VS}, 2'b11);
      reset = 1'b1;
      repeat (FT + 30) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_stream_tx.md
VGA_STREAM_TX -- requirements
Module: vga_stream_tx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync lengths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync lengths in lines.
REQ-005 SHALL have parameter RD_LAT, default 2, fixed pixel-memory read latency in clocks (range 1-4).
REQ-006 SHALL have clk  input  1  clock; all logic on posedge.
REQ-007 SHALL have reset  input  1  reset, synchronous, active-low.
REQ-008 SHALL have enable  input  1  request continuous frame transmission.
REQ-009 SHALL have mem_rd_en  output  1  pixel read strobe.
REQ-010 SHALL have mem_addr  output  19  linear pixel address, y*H_ACTIVE+x.
REQ-011 SHALL have mem_rdata  input  24  {R,G,B} pixel, valid exactly RD_LAT clocks after mem_rd_en.
REQ-012 SHALL have VGA_R, VGA_G, VGA_B  output  8 each  pixel colour.
REQ-013 SHALL have VGA_BLANK_N  output  1  high only for visible pixels.
REQ-014 SHALL have VGA_HS, VGA_VS  output  1 each  active-low syncs.
REQ-015 SHALL have frame_start  output  1  one-clock pulse coincident with pixel (0,0) on the VGA outputs.

Function
REQ-016 SHALL implement FSM IDLE/RUN; IDLE -> RUN on the cycle after enable=1 is sampled in IDLE, with counters starting at h=0, v=0.
REQ-017 SHALL, in RUN, count h_cnt 0..H_TOTAL-1 (H_TOTAL=800 at defaults) and v_cnt 0..V_TOTAL-1 (V_TOTAL=525), incrementing v_cnt on h_cnt wrap.
REQ-018 SHALL, at h=H_TOTAL-1 and v=V_TOTAL-1: wrap to (0,0) staying in RUN if enable=1, else go to IDLE; enable is ignored at all other points, so frames always complete.
REQ-019 SHALL hold counters at 0 in IDLE and issue no reads there.
REQ-020 SHALL assert mem_rd_en (registered, stage 0) exactly when h<H_ACTIVE and v<V_ACTIVE in RUN; mem_addr increments by 1 per read and returns to 0 at every frame start; mem_addr holds its value when mem_rd_en=0.
REQ-021 SHALL delay visible-flag, HS and VS through a RD_LAT-deep pipeline aligned with mem_rdata; all VGA outputs are registered, giving total latency RD_LAT+1 clocks from mem_rd_en to the matching pixel on VGA_*.
REQ-022 SHALL drive VGA_R/G/B = mem_rdata fields when the aligned visible flag is 1, else 0.
REQ-023 SHALL drive VGA_HS low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751) and VGA_VS low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), both pipeline-aligned, in RUN only.
REQ-024 SHALL drain the pipeline after RUN -> IDLE; outputs then settle to blank, HS=VS=1.
REQ-025 SHALL assert frame_start for exactly one clock per frame, never in IDLE.

Reset
REQ-026 SHALL, while reset=0 at a clock edge, force state IDLE, counters 0, pipeline flags cleared, mem_rd_en=0, mem_addr=0, VGA_R/G/B=0, VGA_BLANK_N=0, VGA_HS=1, VGA_VS=1, frame_start=0, effective on the next cycle even mid-line or mid-frame.
REQ-027 SHALL, after reset release, remain in IDLE until enable=1 is sampled.

Verification
REQ-028 SHALL pass: reset 3 clocks, release, enable=1 -> first mem_rd_en addr 0 two cycles after release; VGA_BLANK_N and frame_start first high 3 clocks (RD_LAT+1) later.
REQ-029 SHALL pass: one full frame -> exactly 307200 mem_rd_en pulses, last addr 307199, next frame first addr 0, frame_start period 420000 clocks.
REQ-030 SHALL pass: memory model returning addr as data with RD_LAT=2 -> pixel (x=5,y=1) shows RGB 24'd645; all blanked cycles show RGB 0.
REQ-031 SHALL pass: sync widths -> VGA_HS low 96 consecutive clocks per line, VGA_VS low 1600 consecutive clocks per frame, 640 BLANK_N-high clocks per visible line.
REQ-032 SHALL pass: enable dropped at v=100 -> frame continues to (799,524), then IDLE; no further reads, BLANK_N=0, HS=VS=1 after drain.
REQ-033 SHALL pass: reset=0 at h=300,v=200 -> next clock all outputs at REQ-026 values; after release with enable=1, restart at addr 0.
